psg_write_sequencer: RTL and testbench

//  Timed register-write player that sits directly upstream of the PSG register port (data/address/wr).
//  A host pushes 16-bit commands into an internal FIFO. The block drains the FIFO and issues one-cycle
//  PSG register writes, timed waits and marker events, so note sequences play without host cycle-timing.

---
 rtl/psg_write_sequencer.sv | 172 +++++++++++++++++
 tb/tb_psg_write_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/psg_write_sequencer.sv
// psg_write_sequencer: a FIFO of 16-bit commands drained into timed PSG register
// writes, waits and marker pulses, so note sequences play without host timing.
module psg_write_sequencer #(
   parameter int DEPTH    = 16,
   parameter int TICK_DIV = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              cmd_data,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     enable,
   input  logic                     flush,
   output logic [7:0]               data,
   output logic [3:0]               address,
   output logic                     wr,
   output logic                     marker,
   output logic [7:0]               marker_id,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_RELOAD = PW'(TICK_DIV - 1);
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   // Handshake: a command is pushed on a rising edge where cmd_valid and cmd_ready are
   // both high; cmd_ready is combinational and never depends on cmd_valid.

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [13:0]     wait_cnt_q, wait_cnt_d;
   logic [PW-1:0]   prescale_q, prescale_d;
   logic            wr_q, wr_d;
   logic            marker_q, marker_d;
   logic [7:0]      data_q, data_d;
   logic [3:0]      address_q, address_d;
   logic [7:0]      marker_id_q, marker_id_d;
   logic [15:0]     mem_q [DEPTH];

   logic            push;
   logic            pop;
   logic [15:0]     head;

   assign cmd_ready = ~rst & ~flush & (count_q != FULL_COUNT);
   assign push      = cmd_valid & cmd_ready;
   // Pops only from a non-empty FIFO as it stood before the edge: no push/pop bypass.
   assign pop       = (state_q == ST_IDLE) & enable & ~flush & (count_q != '0);
   assign head      = mem_q[rd_ptr_q];

   // FIFO pointers and occupancy; flush realigns both pointers so the FIFO is truly empty.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Next-state and command decode: IDLE pops and executes, WAIT counts ticks of TICK_DIV cycles.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      prescale_d  = prescale_q;
      wr_d        = 1'b0;
      marker_d    = 1'b0;
      data_d      = data_q;
      address_d   = address_q;
      marker_id_d = marker_id_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  case (head[15:14])
                     2'b00: begin
                        wr_d      = 1'b1;
                        address_d = head[11:8];
                        data_d    = head[7:0];
                     end
                     2'b01: begin
                        if (head[13:0] != '0) begin
                           wait_cnt_d = head[13:0];
                           prescale_d = PRE_RELOAD;
                           state_d    = ST_WAIT;
                        end
                     end
                     2'b10: begin
                        marker_d    = 1'b1;
                        marker_id_d = head[7:0];
                     end
                     default: ;
                  endcase
               end
            end
            ST_WAIT: begin
               if (prescale_q == '0) begin
                  if (wait_cnt_q == 14'd1) begin
                     state_d = ST_IDLE;
                  end else begin
                     wait_cnt_d = wait_cnt_q - 14'd1;
                     prescale_d = PRE_RELOAD;
                  end
               end else begin
                  prescale_d = prescale_q - PW'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wait_cnt_q  <= '0;
         prescale_q  <= '0;
         wr_q        <= 1'b0;
         marker_q    <= 1'b0;
         data_q      <= '0;
         address_q   <= '0;
         marker_id_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wait_cnt_q  <= wait_cnt_d;
         prescale_q  <= prescale_d;
         wr_q        <= wr_d;
         marker_q    <= marker_d;
         data_q      <= data_d;
         address_q   <= address_d;
         marker_id_q <= marker_id_d;
      end
   end

   // Command storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cmd_data;
   end

   assign data       = data_q;
   assign address    = address_q;
   assign wr         = wr_q;
   assign marker     = marker_q;
   assign marker_id  = marker_id_q;
   assign busy       = (state_q == ST_WAIT) | (count_q != '0);
   assign fifo_count = count_q;

endmodule

// File: tb/tb_psg_write_sequencer.sv
// Bench for psg_write_sequencer: directed scenarios followed by random traffic, all
// checked each cycle against a queue-and-countdown reference model.
module tb_psg_write_sequencer;

   localparam int DEPTH    = 16;
   localparam int TICK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cmd_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        enable;
   logic        flush;
   logic [7:0]  data;
   logic [3:0]  address;
   logic        wr;
   logic        marker;
   logic [7:0]  marker_id;
   logic        busy;
   logic [4:0]  fifo_count;

   psg_write_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_data   (cmd_data),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .enable     (enable),
      .flush      (flush),
      .data       (data),
      .address    (address),
      .wr         (wr),
      .marker     (marker),
      .marker_id  (marker_id),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;

   // Reference model: pending commands, cycles left in the current wait, expected outputs.
   logic [15:0] m_q[$];
   int          m_wait;
   logic        m_wr, m_mark;
   logic [3:0]  m_addr;
   logic [7:0]  m_data, m_mid;

   int wr_times[$];
   int mark_times[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_wait = 0;
      m_wr   = 1'b0;
      m_mark = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_mid  = '0;
   endfunction

   // One clock edge of the model: a wait of n ticks blocks pops for n*TICK_DIV edges.
   function automatic void model_edge(input logic v, input logic [15:0] d,
                                      input logic en, input logic fl);
      logic        full;
      logic [15:0] c;
      full   = (m_q.size() == DEPTH);
      m_wr   = 1'b0;
      m_mark = 1'b0;
      if (fl) begin
         m_q.delete();
         m_wait = 0;
      end else begin
         if (m_wait > 0) begin
            m_wait--;
         end else if (en && m_q.size() > 0) begin
            c = m_q.pop_front();
            case (c[15:14])
               2'b00: begin m_wr = 1'b1; m_addr = c[11:8]; m_data = c[7:0]; end
               2'b01: m_wait = int'(c[13:0]) * TICK_DIV;
               2'b10: begin m_mark = 1'b1; m_mid = c[7:0]; end
               default: ;
            endcase
         end
         if (v && !full) m_q.push_back(d);
      end
   endfunction

   task automatic check_outputs();
      chk("wr", 32'(wr), 32'(m_wr));
      chk("marker", 32'(marker), 32'(m_mark));
      chk("address", 32'(address), 32'(m_addr));
      chk("data", 32'(data), 32'(m_data));
      chk("marker_id", 32'(marker_id), 32'(m_mid));
      chk("busy", 32'(busy), 32'((m_wait > 0) || (m_q.size() != 0)));
      chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      if (wr)     wr_times.push_back(cyc_n);
      if (marker) mark_times.push_back(cyc_n);
   endtask

   // Called at a negative edge: drive inputs, check cmd_ready, take the edge, check outputs.
   task automatic cyc(input logic v, input logic [15:0] d, input logic en, input logic fl);
      cmd_valid = v;
      cmd_data  = d;
      enable    = en;
      flush     = fl;
      #1;
      chk("cmd_ready", 32'(cmd_ready), 32'(!fl && (m_q.size() != DEPTH)));
      @(posedge clk);
      model_edge(v, d, en, fl);
      cyc_n++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n, input logic en);
      for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, en, 1'b0);
   endtask

   initial begin
      logic [15:0] c;
      logic [1:0]  op;
      rst       = 1'b1;
      cmd_data  = '0;
      cmd_valid = 1'b0;
      enable    = 1'b0;
      flush     = 1'b0;
      model_reset();

      // Reset: everything low, cmd_ready held low.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wr", 32'(wr), 32'd0);
      chk("rst_marker", 32'(marker), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_address", 32'(address), 32'd0);
      chk("rst_marker_id", 32'(marker_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rel_fifo_count", 32'(fifo_count), 32'd0);

      // Single write: visible for one cycle after the pop edge.
      cyc(1'b1, 16'h0342, 1'b1, 1'b0);
      chk("lat_wr_pre", 32'(wr), 32'd0);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("lat_wr", 32'(wr), 32'd1);
      chk("lat_addr", 32'(address), 32'h3);
      chk("lat_data", 32'(data), 32'h42);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("lat_wr_post", 32'(wr), 32'd0);
      idle(2, 1'b1);

      // WRITE, WAIT 3, WRITE: pops 1 edge apart, then 3*TICK_DIV+1 edges apart.
      wr_times.delete();
      cyc(1'b1, 16'h0010, 1'b1, 1'b0);
      cyc(1'b1, 16'h4003, 1'b1, 1'b0);
      cyc(1'b1, 16'h0120, 1'b1, 1'b0);
      idle(20, 1'b1);
      chk("wait_wr_count", 32'(wr_times.size()), 32'd2);
      if (wr_times.size() == 2)
         chk("wait_spacing", 32'(wr_times[1] - wr_times[0]), 32'(1 + 3 * TICK_DIV + 1));

      // Fill while disabled, overflow push ignored, then drain in order across the wrap.
      for (int i = 0; i < DEPTH + 1; i++) begin
         c = {4'h0, 4'(i), 8'(8'h30 + i)};
         cyc(1'b1, c, 1'b0, 1'b0);
      end
      chk("full_count", 32'(fifo_count), 32'(DEPTH));
      chk("full_ready", 32'(cmd_ready), 32'd0);
      wr_times.delete();
      idle(DEPTH + 4, 1'b1);
      chk("drain_writes", 32'(wr_times.size()), 32'(DEPTH));

      // Flush during a long wait clears everything; the next write runs at once.
      cyc(1'b1, 16'h4064, 1'b1, 1'b0);
      idle(10, 1'b1);
      chk("wait_busy", 32'(busy), 32'd1);
      cyc(1'b0, 16'h0000, 1'b1, 1'b1);
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_count", 32'(fifo_count), 32'd0);
      cyc(1'b1, 16'h0777, 1'b1, 1'b0);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("flush_next_wr", 32'(wr), 32'd1);
      idle(2, 1'b1);

      // MARK, zero-length WAIT, WRITE: write strobe two cycles after the marker pulse.
      wr_times.delete();
      mark_times.delete();
      cyc(1'b1, 16'h80A5, 1'b1, 1'b0);
      cyc(1'b1, 16'h4000, 1'b1, 1'b0);
      cyc(1'b1, 16'h0512, 1'b1, 1'b0);
      idle(4, 1'b1);
      chk("mark_id", 32'(marker_id), 32'hA5);
      chk("mark_seen", 32'(mark_times.size()), 32'd1);
      chk("mark_wr_seen", 32'(wr_times.size()), 32'd1);
      if (mark_times.size() == 1 && wr_times.size() == 1)
         chk("mark_to_wr", 32'(wr_times[0] - mark_times[0]), 32'd2);

      // Random traffic with short waits, occasional disable and flush.
      for (int i = 0; i < 1500; i++) begin
         op = 2'($urandom_range(0, 3));
         if (op == 2'b01) c = {2'b01, 14'($urandom_range(0, 5))};
         else             c = {op, 14'($urandom_range(0, 16383))};
         cyc(1'($urandom_range(0, 1)), c, ($urandom_range(0, 9) < 8),
             ($urandom_range(0, 49) == 0));
      end
      idle(100, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
